// File: rtl/vga_timing_monitor_if.sv
// VGA sync/colour bus as seen between the pixel source and the timing monitor.
interface vga_timing_monitor_if;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;

  modport master (output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
  modport slave  (input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA checker: measures sync timing against the configured mode,
// locks onto the frame and accumulates a per-frame checksum of the active area.
module vga_timing_monitor #(
  parameter int PIX_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic                 CLK1_50,
  input  logic                 RST_N,
  vga_timing_monitor_if.slave  vga,
  input  logic                 CLR_ERR,
  output logic                 LOCKED,
  output logic                 H_ERR,
  output logic                 V_ERR,
  output logic                 FRAME_DONE,
  output logic [15:0]          FRAME_SUM,
  output logic [15:0]          FRAME_CNT,
  output logic [15:0]          LINE_LEN
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [15:0]   HS_W     = 16'(H_SYNC * PIX_DIV);
  localparam logic [15:0]   H_PER    = 16'(H_TOTAL * PIX_DIV);
  localparam logic [15:0]   A0       = 16'((H_SYNC + H_BP) * PIX_DIV);
  localparam logic [15:0]   A_END    = 16'((H_SYNC + H_BP + H_ACTIVE) * PIX_DIV);
  localparam logic [15:0]   V_LO     = 16'(V_SYNC + V_BP);
  localparam logic [15:0]   V_HI     = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0]   VS_W     = 16'(V_SYNC);
  localparam logic [15:0]   V_TOT    = 16'(V_TOTAL);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);

  typedef enum logic [1:0] {S_WAIT_VS, S_MEASURE, S_LOCKED} state_t;

  // input registers and one-cycle-older copies for edge detection
  logic        hs_q, hs_p_q, vs_q, vs_p_q, clr_q;
  logic [11:0] rgb_q;

  logic [15:0]   hcnt_q, hcnt_d, vline_q, vline_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [15:0]   vs_hs_q, vs_hs_d, fhs_q, fhs_d, acc_q, acc_d;
  logic          vs_pend_q, vs_pend_d, h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic          herr_q, herr_d, verr_q, verr_d, done_q, done_d;
  logic [15:0]   sum_q, sum_d, fcnt_q, fcnt_d, llen_q, llen_d;
  state_t        state_q, state_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [15:0] hcnt_inc;
  logic        h_evt, v_evt, any_err, pix_en, enter_wait;

  assign hs_fall = hs_p_q & ~hs_q;
  assign hs_rise = ~hs_p_q & hs_q;
  assign vs_fall = vs_p_q & ~vs_q;
  assign vs_rise = ~vs_p_q & vs_q;

  // hcnt_d is the count for the current cycle: 0 on the HS-fall cycle
  assign hcnt_inc = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
  assign hcnt_d   = hs_fall ? 16'd0 : hcnt_inc;
  assign pcnt_d   = (hs_fall || pcnt_q == PIX_LAST) ? '0 : pcnt_q + PW'(1);

  assign h_evt = (hs_fall & h_armed_q & (hcnt_inc != H_PER))
               | (hs_rise & h_armed_q & (hcnt_d != HS_W))
               | (!hs_fall && hcnt_q == 16'hFFFE);
  assign v_evt = (vs_rise & v_armed_q & (vs_hs_q != VS_W))
               | (vs_fall & v_armed_q & (fhs_q != V_TOT));
  assign any_err = h_evt | v_evt;

  assign pix_en = (pcnt_d == '0) && (hcnt_d >= A0) && (hcnt_d < A_END)
               && (vline_q >= V_LO) && (vline_q < V_HI);

  always_comb begin
    vline_d   = vline_q;
    vs_pend_d = vs_pend_q;
    if (hs_fall) begin
      vline_d   = (vs_fall || vs_pend_q) ? 16'd0
                : (vline_q == 16'hFFFF) ? vline_q : vline_q + 16'd1;
      vs_pend_d = 1'b0;
    end else if (vs_fall) begin
      vs_pend_d = 1'b1;
    end
  end

  // HS falls counted while VS is low, and between consecutive VS falls
  always_comb begin
    vs_hs_d = vs_hs_q;
    fhs_d   = fhs_q;
    if (vs_fall) begin
      vs_hs_d = {15'b0, hs_fall};
      fhs_d   = {15'b0, hs_fall};
    end else if (hs_fall) begin
      if (!vs_q) vs_hs_d = vs_hs_q + 16'd1;
      fhs_d = (fhs_q == 16'hFFFF) ? fhs_q : fhs_q + 16'd1;
    end
  end

  assign acc_d  = vs_fall ? 16'd0 : pix_en ? acc_q + {4'b0, rgb_q} : acc_q;
  assign llen_d = hs_fall ? hcnt_inc : llen_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_WAIT_VS: begin
        if (vs_fall && !any_err) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (any_err) begin
          state_d = S_WAIT_VS;
        end else if (vs_fall) begin
          state_d = S_LOCKED;
          done_d  = 1'b1;
          sum_d   = acc_q;
        end
      end
      S_LOCKED: begin
        if (vs_fall) begin
          done_d = 1'b1;
          sum_d  = acc_q;
          if (!any_err) fcnt_d = fcnt_q + 16'd1;
        end
        if (any_err) state_d = S_WAIT_VS;
      end
      default: state_d = S_WAIT_VS;
    endcase
  end

  assign enter_wait = (state_d == S_WAIT_VS) && (state_q != S_WAIT_VS);

  // a VS fall restarts the frame count, so it re-arms even on the entry cycle
  assign h_armed_d = enter_wait ? 1'b0 : (hs_fall ? 1'b1 : h_armed_q);
  assign v_armed_d = vs_fall ? 1'b1 : (enter_wait ? 1'b0 : v_armed_q);

  assign herr_d = h_evt ? 1'b1 : (clr_q ? 1'b0 : herr_q);
  assign verr_d = v_evt ? 1'b1 : (clr_q ? 1'b0 : verr_q);

  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      hs_q      <= 1'b1;
      hs_p_q    <= 1'b1;
      vs_q      <= 1'b1;
      vs_p_q    <= 1'b1;
      clr_q     <= 1'b0;
      rgb_q     <= '0;
      hcnt_q    <= '0;
      pcnt_q    <= '0;
      vline_q   <= '0;
      vs_pend_q <= 1'b0;
      vs_hs_q   <= '0;
      fhs_q     <= '0;
      acc_q     <= '0;
      h_armed_q <= 1'b0;
      v_armed_q <= 1'b0;
      herr_q    <= 1'b0;
      verr_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      fcnt_q    <= '0;
      llen_q    <= '0;
      state_q   <= S_WAIT_VS;
    end else begin
      hs_q      <= vga.VGA_HS;
      hs_p_q    <= hs_q;
      vs_q      <= vga.VGA_VS;
      vs_p_q    <= vs_q;
      clr_q     <= CLR_ERR;
      rgb_q     <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
      hcnt_q    <= hcnt_d;
      pcnt_q    <= pcnt_d;
      vline_q   <= vline_d;
      vs_pend_q <= vs_pend_d;
      vs_hs_q   <= vs_hs_d;
      fhs_q     <= fhs_d;
      acc_q     <= acc_d;
      h_armed_q <= h_armed_d;
      v_armed_q <= v_armed_d;
      herr_q    <= herr_d;
      verr_q    <= verr_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      fcnt_q    <= fcnt_d;
      llen_q    <= llen_d;
      state_q   <= state_d;
    end
  end

  assign LOCKED     = (state_q == S_LOCKED);
  assign H_ERR      = herr_q;
  assign V_ERR      = verr_q;
  assign FRAME_DONE = done_q;
  assign FRAME_SUM  = sum_q;
  assign FRAME_CNT  = fcnt_q;
  assign LINE_LEN   = llen_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed raster bench: 14-pixel lines (28 cycles), 7-line frames; frame-close
// expectations go into a queue that a negedge monitor drains on FRAME_DONE.
module tb_vga_timing_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic locked, herr, verr, done;
  logic [15:0] fsum, fcnt, llen;

  always #5 clk = ~clk;

  vga_timing_monitor_if vga ();

  vga_timing_monitor #(
    .PIX_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
  ) dut (
    .CLK1_50(clk), .RST_N(rst_n), .vga(vga), .CLR_ERR(clr),
    .LOCKED(locked), .H_ERR(herr), .V_ERR(verr), .FRAME_DONE(done),
    .FRAME_SUM(fsum), .FRAME_CNT(fcnt), .LINE_LEN(llen)
  );

  typedef struct {
    logic [15:0] sum;
    logic [15:0] cnt;
    logic        lk;
    logic        he;
    logic        ve;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [15:0] s, logic [15:0] c, logic lk, logic he, logic ve);
    exp_t e;
    e.sum = s; e.cnt = c; e.lk = lk; e.he = he; e.ve = ve;
    q.push_back(e);
  endtask

  task automatic cyc(logic hs, logic vs, logic [11:0] rgb, logic c);
    @(posedge clk);
    #1;
    vga.VGA_HS = hs;
    vga.VGA_VS = vs;
    vga.VGA_R  = rgb[11:8];
    vga.VGA_G  = rgb[7:4];
    vga.VGA_B  = rgb[3:0];
    clr        = c;
  endtask

  // cycles [c0,c1) of a line: HS low for the first 4 cycles
  task automatic seg(int c0, int c1, logic vs_low, logic [11:0] rgb, int clr_at);
    for (int c = c0; c < c1; c++) cyc(c >= 4, !vs_low, rgb, c == clr_at);
  endtask

  task automatic lines(int l0, int l1, int vs_lines, logic [11:0] rgb, int clr_line);
    for (int l = l0; l < l1; l++) seg(0, 28, l < vs_lines, rgb, (l == clr_line) ? 10 : -1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 12'h000, 1'b0);
  endtask

  // frame-close monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_done: unexpected pulse, sum=%0h cnt=%0d", fsum, fcnt);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_sum", 32'(fsum), 32'(e.sum));
          chk("frame_cnt", 32'(fcnt), 32'(e.cnt));
          chk("frame_locked", 32'(locked), 32'(e.lk));
          chk("frame_h_err", 32'(herr), 32'(e.he));
          chk("frame_v_err", 32'(verr), 32'(e.ve));
        end
      end
    end
  end

  initial begin
    vga.VGA_HS = 1'b1; vga.VGA_VS = 1'b1;
    vga.VGA_R = 4'h0; vga.VGA_G = 4'h0; vga.VGA_B = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // partial raster, then reset mid-line
    lines(0, 3, 1, 12'h001, -1);
    seg(0, 10, 1'b0, 12'h001, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_h_err", 32'(herr), 32'd0);
    chk("rst_v_err", 32'(verr), 32'd0);
    chk("rst_frame_done", 32'(done), 32'd0);
    chk("rst_frame_sum", 32'(fsum), 32'd0);
    chk("rst_frame_cnt", 32'(fcnt), 32'd0);
    chk("rst_line_len", 32'(llen), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // F1..F4 clean; lock at 2nd VS fall
    push(16'd32, 16'd0, 1'b1, 1'b0, 1'b0);  lines(0, 7, 1, 12'h001, -1);
    push(16'd32, 16'd1, 1'b1, 1'b0, 1'b0);  lines(0, 7, 1, 12'h001, -1);
    push(16'd32, 16'd2, 1'b1, 1'b0, 1'b0);  lines(0, 7, 1, 12'h001, -1);
    push(16'hFFE0, 16'd3, 1'b1, 1'b0, 1'b0); lines(0, 7, 1, 12'hFFF, -1);

    // F5: line 3 is 30 cycles
    lines(0, 3, 1, 12'h001, -1);
    seg(0, 30, 1'b0, 12'h001, -1);
    seg(0, 6, 1'b0, 12'h001, -1);
    @(negedge clk);
    chk("long_line_h_err", 32'(herr), 32'd1);
    chk("long_line_locked", 32'(locked), 32'd0);
    chk("long_line_len", 32'(llen), 32'd30);
    seg(6, 28, 1'b0, 12'h001, 6);
    @(negedge clk);
    chk("clr_h_err", 32'(herr), 32'd0);
    lines(5, 7, 1, 12'h001, -1);

    // F6 -> MEASURE, F7 closes with relock
    push(16'd512, 16'd3, 1'b1, 1'b0, 1'b0); lines(0, 7, 1, 12'h010, -1);
    push(16'd32, 16'd4, 1'b1, 1'b0, 1'b0);  lines(0, 7, 1, 12'h001, -1);

    // F8: VS low for 2 lines
    lines(0, 3, 2, 12'h001, -1);
    @(negedge clk);
    chk("vs_wide_v_err", 32'(verr), 32'd1);
    chk("vs_wide_locked", 32'(locked), 32'd0);
    chk("vs_wide_frame_cnt", 32'(fcnt), 32'd4);
    lines(3, 7, 2, 12'h001, 3);
    @(negedge clk);
    chk("clr_v_err", 32'(verr), 32'd0);

    push(16'd8192, 16'd4, 1'b1, 1'b0, 1'b0); lines(0, 7, 1, 12'h100, -1);
    // F10: 8 lines; the closing VS fall flags V_ERR but still reports
    push(16'd32, 16'd4, 1'b0, 1'b0, 1'b1);  lines(0, 8, 1, 12'h001, -1);
    lines(0, 7, 1, 12'h001, 2);
    @(negedge clk);
    chk("f11_v_err", 32'(verr), 32'd0);
    chk("f11_locked", 32'(locked), 32'd0);
    push(16'd480, 16'd4, 1'b1, 1'b0, 1'b0); lines(0, 7, 1, 12'h00F, -1);
    lines(0, 1, 1, 12'h001, -1);
    @(negedge clk);
    chk("relock_locked", 32'(locked), 32'd1);

    // HS stuck high
    idle(70000);
    @(negedge clk);
    chk("stuck_h_err", 32'(herr), 32'd1);
    chk("stuck_locked", 32'(locked), 32'd0);
    chk("stuck_frame_cnt", 32'(fcnt), 32'd4);
    chk("stuck_no_x", 32'($isunknown({locked, herr, verr, done, fsum, fcnt, llen})), 32'd0);
    chk("pending_frames", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
